board_draw_engine: RTL and testbench

- Pixel-drawing datapath for the Connect Four VGA display; sits directly downstream of the draw-control FSM.
- Accepts one draw command at a time (clear board, move pointer, draw piece) and sweeps the pixels of the target square(s), one pixel per clock.
- Produces registered x/y/colour/plot for the 160x120 VGA adapter.
- Pulses done when the command completes, so the controller can leave its drawing state.

---
 rtl/connect4_pkg.sv | 53 +++++
 rtl/board_draw_engine_if.sv | 30 +++
 rtl/board_draw_engine_rect_sweeper.sv | 62 ++++++
 rtl/board_draw_engine.sv | 210 +++++++++++++++++++++
 tb/tb_board_draw_engine.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : connect4_pkg
//  Description : Shared constants and types for the Connect Four draw path:
//                command op codes, colours, board geometry, engine states.
//  Revision    : 1.0 - initial release
// ============================================================================
package connect4_pkg;

   // Board geometry in 160x120 VGA pixels
   localparam int COLS  = 7;
   localparam int ROWS  = 6;
   localparam int PITCH = 8;
   localparam int SIZE  = 4;
   localparam int X0    = 52;
   localparam int Y0    = 30;

   // CLEAR wipes a square region covering the pointer row and the board
   localparam int CLR_DIM = COLS * PITCH;

   // Width of the sweep offset counters, large enough for the CLEAR region
   localparam int SWEEP_W = $clog2(CLR_DIM + 1);

   // Pointer starts over the middle column
   localparam logic [2:0] PTR_HOME = 3'(COLS / 2);

   typedef enum logic [1:0] {
      OP_CLEAR      = 2'd0,
      OP_MOVE_PTR   = 2'd1,
      OP_DRAW_PIECE = 2'd2,
      OP_RSVD       = 2'd3
   } op_e;

   localparam logic [2:0] COL_BG = 3'b000;
   localparam logic [2:0] COL_P1 = 3'b100;
   localparam logic [2:0] COL_P2 = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ERASE = 3'd2,
      ST_DRAW  = 3'd3,
      ST_NOP   = 3'd4,
      ST_FIN   = 3'd5
   } state_e;

   // Player 0 draws red, player 1 draws yellow
   function automatic logic [2:0] player_colour(input logic player);
      return player ? COL_P2 : COL_P1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/board_draw_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : board_draw_engine_if
//  Description : Command channel into the board draw engine (valid/ready
//                handshake plus command fields).
//  Revision    : 1.0 - initial release
// ============================================================================
interface board_draw_engine_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [2:0] cmd_col;
   logic [2:0] cmd_row;
   logic       cmd_player;

   // Controller side: offers commands
   modport master (
      output cmd_valid, cmd_op, cmd_col, cmd_row, cmd_player,
      input  cmd_ready
   );

   // Engine side: accepts commands
   modport slave (
      input  cmd_valid, cmd_op, cmd_col, cmd_row, cmd_player,
      output cmd_ready
   );

endinterface
`default_nettype wire

// File: rtl/board_draw_engine_rect_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : rect_sweeper
//  Description : Raster offset generator. On start, latches the rectangle
//                size and emits one (dx, dy) per cycle, x inner / y outer,
//                pulsing last on the final pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_sweeper #(
   parameter int WB = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [WB-1:0] width,
   input  logic [WB-1:0] height,
   output logic [WB-1:0] dx,
   output logic [WB-1:0] dy,
   output logic          active,
   output logic          last
);

   logic [WB-1:0] width_r;
   logic [WB-1:0] height_r;
   logic          x_end;
   logic          y_end;

   assign x_end  = (dx == width_r - WB'(1));
   assign y_end  = (dy == height_r - WB'(1));
   assign last   = active && x_end && y_end;

   // Offset counters; a start always restarts from (0,0), even on the last pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         width_r  <= '0;
         height_r <= '0;
         dx       <= '0;
         dy       <= '0;
         active   <= 1'b0;
      end else if (start) begin
         width_r  <= width;
         height_r <= height;
         dx       <= '0;
         dy       <= '0;
         active   <= 1'b1;
      end else if (active) begin
         if (x_end) begin
            dx <= '0;
            if (y_end) begin
               dy     <= '0;
               active <= 1'b0;
            end else begin
               dy <= dy + WB'(1);
            end
         end else begin
            dx <= dx + WB'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/board_draw_engine.sv
`default_nettype none
// ============================================================================
//  Module      : board_draw_engine
//  Description : Executes one draw command at a time (clear board, move
//                pointer, draw piece), sweeping one pixel per clock into
//                registered x/y/colour/plot for the VGA adapter, and pulses
//                done on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_draw_engine
   import connect4_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   board_draw_engine_if.slave        cmd,
   output logic [7:0]                x,
   output logic [6:0]                y,
   output logic [2:0]                colour,
   output logic                      plot,
   output logic                      done,
   output logic                      busy,
   output logic [2:0]                ptr_col
);

   state_e               state;
   state_e               state_nx;

   op_e                  op_r;
   logic [2:0]           col_r;
   logic [2:0]           row_r;
   logic                 player_r;

   logic                 accept;
   logic                 cmd_ok;
   logic                 sw_start;
   logic                 sw_big;
   logic                 sw_active;
   logic                 sw_last;
   logic                 in_sweep;
   logic                 done_nx;
   logic [SWEEP_W-1:0]   sw_dim;
   logic [SWEEP_W-1:0]   dx;
   logic [SWEEP_W-1:0]   dy;

   logic [8:0]           ptr_x;
   logic [8:0]           col_x;
   logic [8:0]           row_y;
   logic [8:0]           org_x;
   logic [8:0]           org_y;
   logic [2:0]           pix_colour;

   localparam logic [8:0] PTR_ROW_Y = 9'(Y0 - PITCH);

   assign cmd.cmd_ready = (state == ST_IDLE);
   assign busy          = (state != ST_IDLE);
   assign accept        = cmd.cmd_valid && (state == ST_IDLE);

   // Out-of-range targets and the reserved op become a no-op
   assign cmd_ok = (cmd.cmd_op != OP_RSVD)
                && (int'(cmd.cmd_col) < COLS)
                && !((cmd.cmd_op == OP_DRAW_PIECE) && (int'(cmd.cmd_row) >= ROWS));

   assign sw_dim   = sw_big ? SWEEP_W'(CLR_DIM) : SWEEP_W'(SIZE);
   assign in_sweep = sw_active
                  && ((state == ST_CLEAR) || (state == ST_ERASE) || (state == ST_DRAW));

   rect_sweeper #(
      .WB     (SWEEP_W)
   ) u_sweeper (
      .clk    (clk),
      .reset  (reset),
      .start  (sw_start),
      .width  (sw_dim),
      .height (sw_dim),
      .dx     (dx),
      .dy     (dy),
      .active (sw_active),
      .last   (sw_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, sweeper start and completion strobe
   always_comb begin
      state_nx = state;
      sw_start = 1'b0;
      sw_big   = 1'b0;
      done_nx  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!cmd_ok) begin
                  state_nx = ST_NOP;
               end else begin
                  case (cmd.cmd_op)
                     OP_CLEAR: begin
                        state_nx = ST_CLEAR;
                        sw_start = 1'b1;
                        sw_big   = 1'b1;
                     end
                     OP_MOVE_PTR: begin
                        state_nx = ST_ERASE;
                        sw_start = 1'b1;
                     end
                     OP_DRAW_PIECE: begin
                        state_nx = ST_DRAW;
                        sw_start = 1'b1;
                     end
                     default: state_nx = ST_NOP;
                  endcase
               end
            end
         end
         ST_CLEAR: begin
            if (sw_last) state_nx = ST_FIN;
         end
         ST_ERASE: begin
            // Restart straight into the redraw so the plots stay contiguous
            if (sw_last) begin
               state_nx = ST_DRAW;
               sw_start = 1'b1;
            end
         end
         ST_DRAW: begin
            if (sw_last) state_nx = ST_FIN;
         end
         ST_NOP, ST_FIN: begin
            // done registers on this edge, landing in the cycle cmd_ready rises
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Latch command fields on acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r     <= OP_CLEAR;
         col_r    <= '0;
         row_r    <= '0;
         player_r <= 1'b0;
      end else if (accept) begin
         op_r     <= op_e'(cmd.cmd_op);
         col_r    <= cmd.cmd_col;
         row_r    <= cmd.cmd_row;
         player_r <= cmd.cmd_player;
      end
   end

   // Square origins and colour for the phase being swept
   always_comb begin
      ptr_x      = 9'(X0 + int'(ptr_col) * PITCH);
      col_x      = 9'(X0 + int'(col_r) * PITCH);
      row_y      = 9'(Y0 + int'(row_r) * PITCH);
      org_x      = 9'(X0);
      org_y      = PTR_ROW_Y;
      pix_colour = COL_BG;
      case (state)
         ST_ERASE: begin
            org_x = ptr_x;
         end
         ST_DRAW: begin
            org_x      = col_x;
            org_y      = (op_r == OP_DRAW_PIECE) ? row_y : PTR_ROW_Y;
            pix_colour = player_colour(player_r);
         end
         default: ;
      endcase
   end

   // Registered pixel outputs; x/y/colour hold between commands
   always_ff @(posedge clk) begin
      if (reset) begin
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
      end else begin
         plot <= in_sweep;
         if (in_sweep) begin
            x      <= 8'(org_x + 9'(dx));
            y      <= 7'(org_y + 9'(dy));
            colour <= pix_colour;
         end
      end
   end

   // Completion pulse and pointer position, which moves together with done
   always_ff @(posedge clk) begin
      if (reset) begin
         done    <= 1'b0;
         ptr_col <= PTR_HOME;
      end else begin
         done <= done_nx;
         if ((state == ST_FIN) && (op_r == OP_MOVE_PTR)) begin
            ptr_col <= col_r;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_board_draw_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_draw_engine
//  Description : Self-checking bench for board_draw_engine. A per-cycle
//                expectation queue is built from the drawing rules for each
//                accepted command and compared against the DUT every cycle;
//                literal checks pin first/last pixels and plot counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_draw_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       done;
   logic       busy;
   logic [2:0] ptr_col;

   board_draw_engine_if bus ();

   board_draw_engine dut (
      .clk     (clk),
      .reset   (reset),
      .cmd     (bus),
      .x       (x),
      .y       (y),
      .colour  (colour),
      .plot    (plot),
      .done    (done),
      .busy    (busy),
      .ptr_col (ptr_col)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit plot;
      int px;
      int py;
      int pc;
      bit dn;
      bit rdy;
      int ptr;
   } ent_t;

   ent_t q[$];
   int   mptr  = 3;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;
   int   cnt = 0;
   int   fx, fy, fc, lx, ly, x17, c17;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic ent_t mk(input bit p, input int xx, input int yy, input int cc,
                               input bit d, input bit r, input int pt);
      ent_t e;
      e.plot = p; e.px = xx; e.py = yy; e.pc = cc; e.dn = d; e.rdy = r; e.ptr = pt;
      return e;
   endfunction

   // One expectation per pixel of a square, raster order
   task automatic push_sq(input int ox, input int oy, input int w, input int h, input int c);
      for (int yy = 0; yy < h; yy++)
         for (int xx = 0; xx < w; xx++)
            q.push_back(mk(1'b1, ox + xx, oy + yy, c, 1'b0, 1'b0, mptr));
   endtask

   // Expected cycle trace following acceptance of a command
   task automatic push_cmd(input int op, input int col, input int row, input int pl);
      bit ok;
      int pcol;
      pcol = (pl != 0) ? 6 : 4;
      ok = (op != 3) && (col < 7) && !(op == 2 && row >= 6);
      q.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b0, mptr));
      if (ok) begin
         case (op)
            0: push_sq(52, 22, 56, 56, 0);
            1: begin
               push_sq(52 + mptr * 8, 22, 4, 4, 0);
               push_sq(52 + col * 8, 22, 4, 4, pcol);
               mptr = col;
            end
            2: push_sq(52 + col * 8, 30 + row * 8, 4, 4, pcol);
            default: ;
         endcase
      end
      q.push_back(mk(1'b0, 0, 0, 0, 1'b1, 1'b1, mptr));
   endtask

   // Per-cycle comparison against the expectation queue; idle when empty
   always @(negedge clk) begin
      ent_t e;
      if (chk_en) begin
         if (q.size() > 0) e = q.pop_front();
         else              e = mk(1'b0, 0, 0, 0, 1'b0, 1'b1, mptr);
         chk("plot",    int'(plot),          int'(e.plot));
         chk("done",    int'(done),          int'(e.dn));
         chk("ready",   int'(bus.cmd_ready), int'(e.rdy));
         chk("busy",    int'(busy),          int'(!e.rdy));
         chk("ptr_col", int'(ptr_col),       e.ptr);
         if (e.plot) begin
            chk("x",      int'(x),      e.px);
            chk("y",      int'(y),      e.py);
            chk("colour", int'(colour), e.pc);
         end
         if (plot) begin
            cnt++;
            if (cnt == 1)  begin fx = int'(x); fy = int'(y); fc = int'(colour); end
            if (cnt == 17) begin x17 = int'(x); c17 = int'(colour); end
            lx = int'(x);
            ly = int'(y);
         end
      end
   end

   // Offer a command once the engine is idle; optionally keep valid high
   // (with different fields) for hold cycles after acceptance
   task automatic issue(input int op, input int col, input int row, input int pl, input int hold);
      int t;
      t = 0;
      @(negedge clk); #1;
      while (!bus.cmd_ready && t < 5000) begin
         @(negedge clk); #1;
         t++;
      end
      if (t >= 5000) chk("ready_timeout", 0, 1);
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = 2'(op);
      bus.cmd_col    = 3'(col);
      bus.cmd_row    = 3'(row);
      bus.cmd_player = 1'(pl);
      @(posedge clk);
      push_cmd(op, col, row, pl);
      cnt = 0;
      #1;
      if (hold > 0) begin
         bus.cmd_op  = 2'd2;
         bus.cmd_col = 3'd1;
         bus.cmd_row = 3'd1;
         repeat (hold) @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (q.size() != 0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) chk("done_timeout", 0, 1);
      @(negedge clk); #1;
   endtask

   initial begin
      int t;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 2'd0;
      bus.cmd_col    = 3'd0;
      bus.cmd_row    = 3'd0;
      bus.cmd_player = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_x",      int'(x), 0);
      chk("rst_y",      int'(y), 0);
      chk("rst_colour", int'(colour), 0);
      chk("rst_plot",   int'(plot), 0);
      chk("rst_done",   int'(done), 0);
      chk("rst_ready",  int'(bus.cmd_ready), 1);
      chk("rst_busy",   int'(busy), 0);
      chk("rst_ptr",    int'(ptr_col), 3);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;

      // Piece at the top-left cell, red
      issue(2, 0, 0, 0, 0);
      wait_idle();
      chk("dp_count", cnt, 16);
      chk("dp_first_x", fx, 52);
      chk("dp_first_y", fy, 30);
      chk("dp_colour",  fc, 4);
      chk("dp_last_x",  lx, 55);
      chk("dp_last_y",  ly, 33);
      chk("dp_ptr",     int'(ptr_col), 3);

      // Pointer from column 3 to column 6, yellow
      issue(1, 6, 0, 1, 0);
      wait_idle();
      chk("mv_count",   cnt, 32);
      chk("mv_first_x", fx, 76);
      chk("mv_first_y", fy, 22);
      chk("mv_erase_c", fc, 0);
      chk("mv_draw_x",  x17, 100);
      chk("mv_draw_c",  c17, 6);
      chk("mv_last_x",  lx, 103);
      chk("mv_last_y",  ly, 25);
      chk("mv_ptr",     int'(ptr_col), 6);

      // Pointer to the same column still erases and redraws
      issue(1, 6, 0, 0, 0);
      wait_idle();
      chk("mv_same_count", cnt, 32);
      chk("mv_same_x",     fx, 100);
      chk("mv_same_c",     c17, 4);

      // Clear with valid held high during the sweep
      issue(0, 0, 0, 0, 200);
      wait_idle();
      chk("clr_count",   cnt, 3136);
      chk("clr_first_x", fx, 52);
      chk("clr_first_y", fy, 22);
      chk("clr_last_x",  lx, 107);
      chk("clr_last_y",  ly, 77);
      chk("clr_ptr",     int'(ptr_col), 6);

      // Invalid commands: bad column, bad row, reserved op
      issue(2, 7, 0, 0, 0);
      wait_idle();
      chk("inv_col_count", cnt, 0);
      issue(2, 0, 6, 1, 0);
      wait_idle();
      chk("inv_row_count", cnt, 0);
      issue(3, 1, 1, 0, 0);
      wait_idle();
      chk("inv_op_count", cnt, 0);
      issue(1, 7, 0, 1, 0);
      wait_idle();
      chk("inv_mv_ptr", int'(ptr_col), 6);

      // Back-to-back: second command offered in the first one's done cycle
      issue(2, 3, 5, 1, 0);
      issue(2, 4, 2, 0, 0);
      wait_idle();
      chk("b2b_count",   cnt, 16);
      chk("b2b_first_x", fx, 84);
      chk("b2b_first_y", fy, 46);

      // Reset in the middle of a piece draw
      issue(2, 2, 3, 1, 0);
      t = 0;
      while (cnt < 8 && t < 100) begin
         @(negedge clk); #1;
         t++;
      end
      if (t >= 100) chk("mid_timeout", 0, 1);
      reset = 1'b1;
      q.delete();
      mptr = 3;
      @(negedge clk); #1;
      chk("mid_plot",  int'(plot), 0);
      chk("mid_ready", int'(bus.cmd_ready), 1);
      chk("mid_ptr",   int'(ptr_col), 3);
      chk("mid_done",  int'(done), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_count", cnt, 8);

      // Engine usable again after the abort
      issue(2, 6, 5, 0, 0);
      wait_idle();
      chk("post_count",   cnt, 16);
      chk("post_first_x", fx, 100);
      chk("post_first_y", fy, 70);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
